// File: rtl/mpu_load.sv
// Streams a row-major M x N matrix from the memory-side loader into one matrix register, one element per write.
// Latency: 1 cycle from accepted beat to register-file write strobe; completion pulse coincides with the final strobe.
// Backpressure: ready is high only while loading; a low valid stalls with no timeout, and beats after the last are refused.
module mpu_load #(
    parameter int FP              = 32,
    parameter int MBITS           = 2,
    parameter int NBITS           = 2,
    parameter int MATRIX_REG_SIZE = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en_in,
    input  logic [MATRIX_REG_SIZE-1:0] load_addr_in,
    input  logic [MBITS:0]             mem_m_load_size_in,
    input  logic [NBITS:0]             mem_n_load_size_in,
    input  logic [FP-1:0]              mem_load_element_in,
    input  logic                       mem_load_valid_in,
    output logic                       mem_load_ready_out,
    output logic                       reg_load_en_out,
    output logic [FP-1:0]              reg_load_element_out,
    output logic [MBITS:0]             reg_i_load_loc_out,
    output logic [NBITS:0]             reg_j_load_loc_out,
    output logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out,
    output logic [MBITS:0]             reg_m_load_size_out,
    output logic [NBITS:0]             reg_n_load_size_out,
    output logic                       reg_load_complete_out,
    output logic                       load_busy_out,
    output logic                       load_error_out
);

    typedef enum logic [1:0] {
        LOAD_IDLE   = 2'd0,
        LOAD_MATRIX = 2'd1,
        LOAD_DONE   = 2'd2
    } state_t;

    localparam logic [MBITS:0] M_MAX = (MBITS+1)'(2**MBITS);
    localparam logic [NBITS:0] N_MAX = (NBITS+1)'(2**NBITS);

    state_t         state;
    state_t         state_nxt;
    logic [MBITS:0] row;
    logic [NBITS:0] col;
    logic [MBITS:0] m_last;
    logic [NBITS:0] n_last;
    logic           size_ok;
    logic           start;
    logic           beat;
    logic           col_wrap;
    logic           last_beat;

    assign size_ok = (mem_m_load_size_in != '0) && (mem_n_load_size_in != '0) &&
                     (mem_m_load_size_in <= M_MAX) && (mem_n_load_size_in <= N_MAX);
    assign start   = (state == LOAD_IDLE) && load_en_in;

    assign m_last    = reg_m_load_size_out - (MBITS+1)'(1);
    assign n_last    = reg_n_load_size_out - (NBITS+1)'(1);
    assign beat      = mem_load_ready_out && mem_load_valid_in;
    assign col_wrap  = (col == n_last);
    assign last_beat = beat && col_wrap && (row == m_last);

    assign mem_load_ready_out    = (state == LOAD_MATRIX);
    assign reg_load_complete_out = (state == LOAD_DONE);
    assign load_busy_out         = (state != LOAD_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD_IDLE:   if (start && size_ok) state_nxt = LOAD_MATRIX;
            LOAD_MATRIX: if (last_beat) state_nxt = LOAD_DONE;
            LOAD_DONE:   state_nxt = LOAD_IDLE;
            default:     state_nxt = LOAD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row                  <= '0;
            col                  <= '0;
            reg_load_en_out      <= 1'b0;
            reg_load_element_out <= '0;
            reg_i_load_loc_out   <= '0;
            reg_j_load_loc_out   <= '0;
            reg_load_addr_out    <= '0;
            reg_m_load_size_out  <= '0;
            reg_n_load_size_out  <= '0;
            load_error_out       <= 1'b0;
        end else begin
            reg_load_en_out <= beat;
            load_error_out  <= start && !size_ok;
            // A rejected request leaves the previous destination and sizes untouched.
            if (start && size_ok) begin
                reg_load_addr_out   <= load_addr_in;
                reg_m_load_size_out <= mem_m_load_size_in;
                reg_n_load_size_out <= mem_n_load_size_in;
                row                 <= '0;
                col                 <= '0;
            end
            if (beat) begin
                reg_load_element_out <= mem_load_element_in;
                reg_i_load_loc_out   <= row;
                reg_j_load_loc_out   <= col;
                if (col_wrap) begin
                    col <= '0;
                    row <= row + (MBITS+1)'(1);
                end else begin
                    col <= col + (NBITS+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mpu_load.sv
// Directed bench for mpu_load: full loads under continuous and alternating valid, size errors, reset abort, ignored requests.
module tb_mpu_load;

    localparam int FP    = 32;
    localparam int MBITS = 2;
    localparam int NBITS = 2;
    localparam int MRS   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_en;
    logic [MRS-1:0]   load_addr;
    logic [MBITS:0]   m_size;
    logic [NBITS:0]   n_size;
    logic [FP-1:0]    element;
    logic             valid;
    logic             ready;
    logic             wr_en;
    logic [FP-1:0]    wr_dat;
    logic [MBITS:0]   wr_i;
    logic [NBITS:0]   wr_j;
    logic [MRS-1:0]   wr_addr;
    logic [MBITS:0]   wr_m;
    logic [NBITS:0]   wr_n;
    logic             complete;
    logic             busy;
    logic             error;

    int tests = 0;
    int fails = 0;
    logic [FP-1:0] elem [0:15];

    always #5 clk = ~clk;

    mpu_load #(.FP(FP), .MBITS(MBITS), .NBITS(NBITS), .MATRIX_REG_SIZE(MRS)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .load_en_in            (load_en),
        .load_addr_in          (load_addr),
        .mem_m_load_size_in    (m_size),
        .mem_n_load_size_in    (n_size),
        .mem_load_element_in   (element),
        .mem_load_valid_in     (valid),
        .mem_load_ready_out    (ready),
        .reg_load_en_out       (wr_en),
        .reg_load_element_out  (wr_dat),
        .reg_i_load_loc_out    (wr_i),
        .reg_j_load_loc_out    (wr_j),
        .reg_load_addr_out     (wr_addr),
        .reg_m_load_size_out   (wr_m),
        .reg_n_load_size_out   (wr_n),
        .reg_load_complete_out (complete),
        .load_busy_out         (busy),
        .load_error_out        (error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] base);
        for (int k = 0; k < 16; k++) elem[k] = base + 32'(k);
    endtask

    // Issues a load at one negedge, then watches outputs each later negedge.
    // alt=1 drives valid only on odd cycles; pulse_c>0 re-requests a different load on that cycle.
    task automatic run_load(input string name, input logic [MRS-1:0] addr, input int m, input int n,
                            input bit alt, input int pulse_c);
        int strobes = 0, completes = 0, comp_cyc = -1, last_str = -2;
        int busy_cnt = 0, ready_cnt = 0, beats = 0, idle_after = 0;
        bit seen_busy = 0, done = 0;
        int mn = m * n;
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = addr;
        m_size    = (MBITS+1)'(m);
        n_size    = (NBITS+1)'(n);
        valid     = 1'b0;
        for (int c = 1; c <= 80 && !done; c++) begin
            @(negedge clk);
            load_en = (c == pulse_c);
            if (c == pulse_c) begin
                load_addr = addr ^ 3'b111;
                m_size    = 3'd1;
                n_size    = 3'd1;
            end
            if (wr_en) begin
                chk({name, ".i"}, 64'(wr_i), 64'(strobes / n));
                chk({name, ".j"}, 64'(wr_j), 64'(strobes % n));
                chk({name, ".data"}, 64'(wr_dat), 64'(elem[strobes & 15]));
                last_str = c;
                strobes++;
            end
            if (complete) begin
                completes++;
                comp_cyc = c;
            end
            if (ready) ready_cnt++;
            if (busy) begin
                busy_cnt++;
                seen_busy = 1;
            end else if (seen_busy) begin
                idle_after++;
                if (idle_after == 3) done = 1;
            end
            valid   = alt ? (c % 2 == 1) : 1'b1;
            element = elem[beats & 15];
            if (ready && valid) beats++;
        end
        valid = 1'b0;
        chk({name, ".finished"}, 64'(done), 64'd1);
        chk({name, ".strobes"}, 64'(strobes), 64'(mn));
        chk({name, ".completes"}, 64'(completes), 64'd1);
        chk({name, ".complete_with_last"}, 64'(comp_cyc), 64'(last_str));
        chk({name, ".complete_cycle"}, 64'(comp_cyc), alt ? 64'(2 * mn) : 64'(mn + 1));
        chk({name, ".busy_cycles"}, 64'(busy_cnt), alt ? 64'(2 * mn) : 64'(mn + 1));
        chk({name, ".ready_cycles"}, 64'(ready_cnt), alt ? 64'(2 * mn - 1) : 64'(mn));
        chk({name, ".addr"}, 64'(wr_addr), 64'(addr));
        chk({name, ".m"}, 64'(wr_m), 64'(m));
        chk({name, ".n"}, 64'(wr_n), 64'(n));
    endtask

    task automatic bad_size(input string name, input logic [MBITS:0] m, input logic [NBITS:0] n,
                            input logic [MBITS:0] keep_m, input logic [NBITS:0] keep_n);
        @(negedge clk);
        load_en = 1'b1;
        m_size  = m;
        n_size  = n;
        @(negedge clk);
        load_en = 1'b0;
        chk({name, ".error"}, 64'(error), 64'd1);
        chk({name, ".ready"}, 64'(ready), 64'd0);
        chk({name, ".busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({name, ".error_pulse"}, 64'(error), 64'd0);
        chk({name, ".no_strobe"}, 64'(wr_en), 64'd0);
        chk({name, ".m_kept"}, 64'(wr_m), 64'(keep_m));
        chk({name, ".n_kept"}, 64'(wr_n), 64'(keep_n));
    endtask

    initial begin
        rst       = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        m_size    = '0;
        n_size    = '0;
        element   = '0;
        valid     = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.outputs", 64'({ready, wr_en, wr_dat, wr_i, wr_j, wr_addr, wr_m, wr_n, complete, busy, error}), 64'd0);
        rst = 1'b1;

        // 2x3 with float elements 1.0 .. 6.0
        elem[0] = 32'h3F80_0000; elem[1] = 32'h4000_0000; elem[2] = 32'h4040_0000;
        elem[3] = 32'h4080_0000; elem[4] = 32'h40A0_0000; elem[5] = 32'h40C0_0000;
        run_load("t1_2x3", 3'd5, 2, 3, 1'b0, 0);

        fill(32'hC0DE_0100);
        run_load("t2_4x4_alt", 3'd3, 4, 4, 1'b1, 0);

        fill(32'h0000_0A00);
        run_load("t3_1x1", 3'd1, 1, 1, 1'b0, 0);

        bad_size("t4_m0", 3'd0, 3'd2, 3'd1, 3'd1);
        bad_size("t4_n5", 3'd2, 3'd5, 3'd1, 3'd1);

        // 4x4 aborted by reset after three accepted beats
        fill(32'h0BAD_0000);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 3'd6;
        m_size    = 3'd4;
        n_size    = 3'd4;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            load_en = 1'b0;
            element = elem[c - 1];
            valid   = (c <= 3);
        end
        chk("t5.busy_before_reset", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5.outputs_zero", 64'({ready, wr_en, wr_dat, wr_i, wr_j, wr_addr, wr_m, wr_n, complete, busy, error}), 64'd0);
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5.no_strobe_after_release", 64'({wr_en, complete, busy}), 64'd0);
        fill(32'h0000_5500);
        run_load("t5_2x2", 3'd2, 2, 2, 1'b0, 0);

        // requests while loading and in the done cycle are ignored
        fill(32'h0000_6600);
        run_load("t6_mid", 3'd4, 2, 2, 1'b0, 2);
        fill(32'h0000_6700);
        run_load("t6_done", 3'd7, 2, 2, 1'b0, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
